instruction_fetch_stage: RTL and testbench

Parametrised instruction fetch stage with a registered IF/ID output. It holds the program counter, drives a synchronous instruction ROM (1-cycle read latency, external to this block), and supports jumps, pipeline stalls and squashing of wrong-path fetches. It sits at the front of the pipeline, between the instruction memory and the decode stage, and replaces the fixed-width, jump-less fetch block.

---
 rtl/instruction_fetch_stage.sv | 122 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, synchronous-ROM address generation and IF/ID register.
// Optional debug port set (halt input, fetch counter, live PC) enabled by defining IF_DEBUG_EN.
module instruction_fetch_stage #(
  parameter int unsigned       WIDTH_B    = 32,
  parameter int unsigned       ADDR_B     = 10,
  parameter logic [ADDR_B-1:0] RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_B-1:0]  jump_addr,
  output logic [ADDR_B-1:0]  rom_addr,
  input  logic [WIDTH_B-1:0] rom_data,
  output logic [WIDTH_B-1:0] instr_o,
  output logic [ADDR_B-1:0]  pc_o,
  output logic [ADDR_B-1:0]  pc_next_o,
  output logic               valid_o
`ifdef IF_DEBUG_EN
  ,
  input  logic               dbg_halt,
  output logic [31:0]        dbg_fetch_count,
  output logic [ADDR_B-1:0]  dbg_pc
`endif
);

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [WIDTH_B-1:0] instr;
    logic [ADDR_B-1:0]  pc;
    logic [ADDR_B-1:0]  pc_next;
    logic               valid;
  } ifid_t;

  logic [ADDR_B-1:0] pc_q;
  logic [ADDR_B-1:0] pc_inc_c;
  logic              hold_c;
  logic              load_c;
  ifid_t             ifid_q, ifid_d;

  // Debug halt is indistinguishable from a hazard stall.
`ifdef IF_DEBUG_EN
  assign hold_c = stall | dbg_halt;
`else
  assign hold_c = stall;
`endif

  assign pc_inc_c = pc_q + ADDR_B'(1);
  assign load_c   = !reset && !jump_en && !hold_c;

  // ROM address select; pc_q always tracks the address whose data is on rom_data.
  always_comb begin
    rom_addr = pc_inc_c;
    if (reset) begin
      rom_addr = RESET_ADDR;
    end else if (jump_en) begin
      rom_addr = jump_addr;
    end else if (hold_c) begin
      rom_addr = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= rom_addr;
  end

  // IF/ID next value: a jump squashes the fetch currently returning from the ROM.
  always_comb begin
    ifid_d = ifid_q;
    if (reset) begin
      ifid_d.instr   = '0;
      ifid_d.pc      = RESET_ADDR;
      ifid_d.pc_next = RESET_ADDR + ADDR_B'(1);
      ifid_d.valid   = 1'b0;
    end else if (jump_en) begin
      ifid_d.instr   = rom_data;
      ifid_d.pc      = pc_q;
      ifid_d.pc_next = pc_inc_c;
      ifid_d.valid   = 1'b0;
    end else if (!hold_c) begin
      ifid_d.instr   = rom_data;
      ifid_d.pc      = pc_q;
      ifid_d.pc_next = pc_inc_c;
      ifid_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    ifid_q <= ifid_d;
  end

  assign instr_o   = ifid_q.instr;
  assign pc_o      = ifid_q.pc;
  assign pc_next_o = ifid_q.pc_next;
  assign valid_o   = ifid_q.valid;

`ifdef IF_DEBUG_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  // Counts every edge on which a real instruction enters IF/ID.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (reset) begin
      fetch_cnt_d = '0;
    end else if (load_c) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    fetch_cnt_q <= fetch_cnt_d;
  end

  assign dbg_fetch_count = fetch_cnt_q;
  assign dbg_pc          = pc_q;
`else
  logic unused_c;
  assign unused_c = load_c ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, wrap sequence and randomized run
// against a fetch-sequence reference model. Define IF_DEBUG_EN to also exercise debug ports.
module tb_instruction_fetch_stage;

  localparam int unsigned WB = 32;
  localparam int unsigned AB = 10;
  localparam logic [AB-1:0] RA = '0;

  logic          clk = 1'b0;
  logic          reset, stall, jump_en;
  logic [AB-1:0] jump_addr, rom_addr, pc_o, pc_next_o;
  logic [WB-1:0] rom_data, instr_o;
  logic          valid_o;
  logic          halt;
`ifdef IF_DEBUG_EN
  logic [31:0]   dbg_fetch_count;
  logic [AB-1:0] dbg_pc;
`endif

  logic [WB-1:0] mem [0:(1<<AB)-1];

  instruction_fetch_stage #(.WIDTH_B(WB), .ADDR_B(AB), .RESET_ADDR(RA)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr_o(instr_o), .pc_o(pc_o),
    .pc_next_o(pc_next_o), .valid_o(valid_o)
`ifdef IF_DEBUG_EN
    , .dbg_halt(halt), .dbg_fetch_count(dbg_fetch_count), .dbg_pc(dbg_pc)
`endif
  );

  always #5 clk = ~clk;

  // External synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= mem[rom_addr];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: the address of the next instruction to be delivered, plus expected IF/ID.
  logic          m_ok = 1'b0;
  logic [AB-1:0] m_fetch;
  logic          m_valid, m_known;
  logic [AB-1:0] m_pc, m_next;
  logic [WB-1:0] m_instr;
  int unsigned   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input logic j, input logic [AB-1:0] ja);
    if (r) begin
      m_ok = 1'b1; m_valid = 1'b0; m_known = 1'b1; m_instr = '0;
      m_pc = RA; m_next = RA + 10'd1; m_fetch = RA; m_cnt = 0;
    end else if (j) begin
      m_valid = 1'b0; m_known = 1'b0; m_fetch = ja;
    end else if (!s) begin
      m_valid = 1'b1; m_known = 1'b1; m_pc = m_fetch; m_next = m_fetch + 10'd1;
      m_instr = 32'hA000_0000 + 32'(m_fetch);
      m_fetch = m_fetch + 10'd1;
      m_cnt++;
    end
  endtask

  // One cycle: drive at negedge, optionally check rom_addr, clock, settle past the edge.
  task automatic step(input logic r, input logic s, input logic j, input logic [AB-1:0] ja,
                      input logic h, input logic chk_addr);
    logic [AB-1:0] ea;
    @(negedge clk);
    reset = r; stall = s; jump_en = j; jump_addr = ja; halt = h;
    #1;
    if (chk_addr && m_ok) begin
      if (r) ea = RA;
      else if (j) ea = ja;
      else if (s || h) ea = m_fetch;
      else ea = m_fetch + 10'd1;
      chk("rom_addr", 32'(rom_addr), 32'(ea));
    end
    @(posedge clk);
    model_update(r, s || h, j, ja);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
    if (m_known) begin
      chk({tag, ".pc"}, 32'(pc_o), 32'(m_pc));
      chk({tag, ".pc_next"}, 32'(pc_next_o), 32'(m_next));
      chk({tag, ".instr"}, instr_o, m_instr);
    end
`ifdef IF_DEBUG_EN
    chk({tag, ".dbg_cnt"}, dbg_fetch_count, m_cnt);
    chk({tag, ".dbg_pc"}, 32'(dbg_pc), 32'(m_fetch));
`endif
  endtask

  typedef struct {
    logic          rst, stl, jmp;
    logic [AB-1:0] ja;
    logic          ev;
    logic          full;
    logic [AB-1:0] epc, enext;
    logic [WB-1:0] einstr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic j, input logic [AB-1:0] ja,
                              input logic ev, input logic full, input logic [AB-1:0] epc,
                              input logic [AB-1:0] enext, input logic [WB-1:0] ei);
    vec_t v;
    v.rst = r; v.stl = s; v.jmp = j; v.ja = ja; v.ev = ev; v.full = full;
    v.epc = epc; v.enext = enext; v.einstr = ei;
    return v;
  endfunction

  function automatic vec_t run(input logic [AB-1:0] pc, input logic [AB-1:0] nx);
    return mk(0, 0, 0, 0, 1, 1, pc, nx, 32'hA000_0000 + 32'(pc));
  endfunction

  initial begin
    for (int i = 0; i < (1 << AB); i++) mem[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = '0; halt = 1'b0;

    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 10'h000, 10'h001, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 10'h000, 10'h001, 32'h0));
    for (int p = 0; p <= 5; p++) vecs.push_back(run(10'(p), 10'(p + 1)));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, 10'h005, 10'h006, 32'hA000_0005));
    vecs.push_back(run(10'h006, 10'h007));
    vecs.push_back(run(10'h007, 10'h008));
    vecs.push_back(mk(0, 0, 1, 10'h200, 0, 0, 0, 0, 0));
    vecs.push_back(run(10'h200, 10'h201));
    vecs.push_back(mk(0, 1, 1, 10'h010, 0, 0, 0, 0, 0));
    vecs.push_back(run(10'h010, 10'h011));
    vecs.push_back(mk(0, 0, 1, 10'h03E, 0, 0, 0, 0, 0));
    vecs.push_back(run(10'h03E, 10'h03F));
    vecs.push_back(run(10'h03F, 10'h040));
    vecs.push_back(run(10'h040, 10'h041));
    vecs.push_back(mk(1, 1, 1, 10'h123, 0, 1, 10'h000, 10'h001, 32'h0));
    vecs.push_back(run(10'h000, 10'h001));
    vecs.push_back(run(10'h001, 10'h002));
    vecs.push_back(run(10'h002, 10'h003));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].jmp, vecs[i].ja, 1'b0, 1'b0);
      chk($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(vecs[i].ev));
      if (vecs[i].full) begin
        chk($sformatf("vec%0d.pc", i), 32'(pc_o), 32'(vecs[i].epc));
        chk($sformatf("vec%0d.pc_next", i), 32'(pc_next_o), 32'(vecs[i].enext));
        chk($sformatf("vec%0d.instr", i), instr_o, vecs[i].einstr);
      end
    end
    check_model("post_table");

    // Wrap-around at the top of the address space.
    step(0, 0, 1, 10'h3FE, 0, 1);
    chk("wrap.bubble", 32'(valid_o), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap.pc0", 32'(pc_o), 32'h3FE);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap.pc1", 32'(pc_o), 32'h3FF);
    chk("wrap.next1", 32'(pc_next_o), 32'h000);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap.pc2", 32'(pc_o), 32'h000);
    chk("wrap.instr2", instr_o, 32'hA000_0000);
    chk("wrap.valid2", 32'(valid_o), 32'd1);

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic r, s, j, h;
      r = ($urandom_range(0, 63) == 0);
      j = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 3) == 0);
`ifdef IF_DEBUG_EN
      h = ($urandom_range(0, 7) == 0);
`else
      h = 1'b0;
`endif
      step(r, s, j, 10'($urandom), h, 1'b1);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
